// File: rtl/sccb_pkg.sv
// rtl/sccb_pkg.sv - shared SCCB definitions for the target and master blocks
package sccb_pkg;

    // Decoder phases. Every byte phase also owns its trailing 9th-bit slot.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DEV_ADDR = 3'd1,
        ST_REG_ADDR = 3'd2,
        ST_WR_DATA  = 3'd3,
        ST_RD_DATA  = 3'd4,
        ST_IGNORE   = 3'd5
    } sccb_state_t;

    localparam logic [7:0] DEFAULT_DEVICE_ADDR = 8'h42;
    localparam int         BITS_PER_PHASE      = 9;

endpackage

// File: rtl/sccb_line_sync.sv
// rtl/sccb_line_sync.sv - SCL/SDA synchronizers, SCL edge and START/STOP detection
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   scl, sda            raw bus lines
//   sda_s               synchronized SDA
//   scl_rise, scl_fall  one-clk pulses on synchronized SCL edges
//   start_det, stop_det one-clk pulses for START / STOP conditions
module sccb_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl,
    input  logic sda,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_pipe;
    logic [SYNC_STAGES-1:0] sda_pipe;
    logic                   scl_d;
    logic                   sda_d;
    logic                   scl_s;

    // Reset to 1 so an idle (pulled-up) bus produces no edges on release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_pipe <= '1;
            sda_pipe <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_pipe <= {scl_pipe[SYNC_STAGES-2:0], scl};
            sda_pipe <= {sda_pipe[SYNC_STAGES-2:0], sda};
            scl_d    <= scl_pipe[SYNC_STAGES-1];
            sda_d    <= sda_pipe[SYNC_STAGES-1];
        end
    end

    assign scl_s    = scl_pipe[SYNC_STAGES-1];
    assign sda_s    = sda_pipe[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_d;
    assign scl_fall = ~scl_s & scl_d;

    // SCL must be high on both sides of the SDA edge so an SDA change that
    // coincides with an SCL edge is never mistaken for a bus condition.
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/sccb_target.sv
// rtl/sccb_target.sv - SCCB target decoding 3-phase register writes
//
// Build option: define SCCB_READ_EN to answer the read address by driving a
// byte of reg_rd_data on SDA; otherwise the read address is treated as a miss
// and SDA is never driven.
//
// Ports:
//   clk, rst_n        system clock (>= 8x SCL), asynchronous active-low reset
//   sccb_scl          SCCB clock from master
//   sccb_sda          SCCB data (driven only during read data bits)
//   reg_wr_valid      one-clk write strobe
//   reg_wr_addr/data  register address/data of the write
//   reg_rd_addr       current read pointer
//   reg_rd_data       register contents at reg_rd_addr
//   busy              high from START to STOP
//   addr_miss         one-clk pulse on a non-matching device address
module sccb_target
    import sccb_pkg::*;
#(
    parameter logic [7:0] DEVICE_ADDR = DEFAULT_DEVICE_ADDR,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sccb_scl,
    inout  wire        sccb_sda,
    output logic       reg_wr_valid,
    output logic [7:0] reg_wr_addr,
    output logic [7:0] reg_wr_data,
    output logic [7:0] reg_rd_addr,
    input  logic [7:0] reg_rd_data,
    output logic       busy,
    output logic       addr_miss
);

`ifdef SCCB_READ_EN
    localparam bit READ_EN = 1'b1;
`else
    localparam bit READ_EN = 1'b0;
`endif

    localparam logic [3:0] LAST_SLOT = 4'(BITS_PER_PHASE - 1);
    localparam logic [3:0] LAST_BIT  = LAST_SLOT - 4'd1;
    localparam logic [7:0] WR_ADDR   = DEVICE_ADDR;
    localparam logic [7:0] RD_ADDR   = DEVICE_ADDR | 8'h01;

    logic sda_s, scl_rise, scl_fall, start_det, stop_det;

    sccb_line_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_line_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl       (sccb_scl),
        .sda       (sccb_sda),
        .sda_s     (sda_s),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    sccb_state_t state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [6:0]  shreg_q, shreg_d;
    logic [7:0]  rx_byte;
    logic [7:0]  tx_q, tx_d;
    logic        oe_q, oe_d;
    logic        out_q, out_d;
    logic        busy_q, busy_d;
    logic        wr_valid_q, wr_valid_d;
    logic        miss_q, miss_d;
    logic [7:0]  wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic [7:0]  rd_addr_q, rd_addr_d;
    logic        sda_oe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            tx_q       <= '0;
            oe_q       <= 1'b0;
            out_q      <= 1'b1;
            busy_q     <= 1'b0;
            wr_valid_q <= 1'b0;
            miss_q     <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            rd_addr_q  <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            tx_q       <= tx_d;
            oe_q       <= oe_d;
            out_q      <= out_d;
            busy_q     <= busy_d;
            wr_valid_q <= wr_valid_d;
            miss_q     <= miss_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            rd_addr_q  <= rd_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        tx_d       = tx_q;
        oe_d       = oe_q;
        out_d      = out_q;
        busy_d     = busy_q;
        wr_valid_d = 1'b0;
        miss_d     = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        rd_addr_d  = rd_addr_q;
        rx_byte    = {shreg_q, sda_s};

        // Bus conditions win over any bit activity in the same cycle.
        if (stop_det) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            busy_d    = 1'b0;
            oe_d      = 1'b0;
        end else if (start_det) begin
            state_d   = ST_DEV_ADDR;
            bit_cnt_d = '0;
            busy_d    = 1'b1;
            oe_d      = 1'b0;
        end else begin
            case (state_q)
                ST_DEV_ADDR, ST_REG_ADDR, ST_WR_DATA: begin
                    if (scl_rise) begin
                        if (bit_cnt_q == LAST_SLOT) begin
                            // 9th slot: never driven here, just advance.
                            bit_cnt_d = '0;
                            if (state_q == ST_DEV_ADDR)
                                state_d = shreg_q[0] ? ST_RD_DATA : ST_REG_ADDR;
                            else if (state_q == ST_REG_ADDR)
                                state_d = ST_WR_DATA;
                            else
                                state_d = ST_IGNORE;
                        end else begin
                            shreg_d   = rx_byte[6:0];
                            bit_cnt_d = bit_cnt_q + 4'd1;
                            if (bit_cnt_q == LAST_BIT) begin
                                if (state_q == ST_DEV_ADDR) begin
                                    if (READ_EN && rx_byte == RD_ADDR) begin
                                        tx_d = reg_rd_data;
                                    end else if (rx_byte != WR_ADDR) begin
                                        miss_d  = 1'b1;
                                        state_d = ST_IGNORE;
                                    end
                                end else if (state_q == ST_REG_ADDR) begin
                                    wr_addr_d = rx_byte;
                                    rd_addr_d = rx_byte;
                                end else begin
                                    wr_data_d  = rx_byte;
                                    wr_valid_d = 1'b1;
                                end
                            end
                        end
                    end
                end
                ST_RD_DATA: begin
                    // Data changes only while SCL is low; out_q holds it
                    // stable through the following high phase.
                    if (scl_fall) begin
                        if (bit_cnt_q == LAST_SLOT) begin
                            oe_d = 1'b0;
                        end else begin
                            oe_d  = 1'b1;
                            out_d = tx_q[7];
                        end
                    end
                    if (scl_rise) begin
                        if (bit_cnt_q == LAST_SLOT) begin
                            bit_cnt_d = '0;
                            oe_d      = 1'b0;
                            state_d   = ST_IGNORE;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                            tx_d      = {tx_q[6:0], 1'b0};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Gating with the bus conditions releases SDA in the detecting cycle.
    assign sda_oe   = READ_EN && oe_q && !start_det && !stop_det;
    assign sccb_sda = sda_oe ? out_q : 1'bz;

    assign reg_wr_valid = wr_valid_q;
    assign reg_wr_addr  = wr_addr_q;
    assign reg_wr_data  = wr_data_q;
    assign reg_rd_addr  = rd_addr_q;
    assign busy         = busy_q;
    assign addr_miss    = miss_q;

endmodule

// File: tb/tb_sccb_target.sv
// tb/tb_sccb_target.sv - self-checking bench for sccb_target
module tb_sccb_target;

    localparam int         Q    = 4;
    localparam int         SYNC = 2;
    localparam logic [7:0] DEV  = 8'h42;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       scl     = 1'b1;
    logic       m_low   = 1'b0;
    logic [7:0] rd_data = 8'h00;
    wire        sda_bus;
    logic       wr_valid, busy, miss;
    logic [7:0] wr_addr, wr_data, rd_addr;

    pullup (sda_bus);
    assign sda_bus = m_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    sccb_target #(
        .DEVICE_ADDR(DEV),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sccb_scl     (scl),
        .sccb_sda     (sda_bus),
        .reg_wr_valid (wr_valid),
        .reg_wr_addr  (wr_addr),
        .reg_wr_data  (wr_data),
        .reg_rd_addr  (rd_addr),
        .reg_rd_data  (rd_data),
        .busy         (busy),
        .addr_miss    (miss)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Observation side
    int          cyc      = 0;
    int          rise_cyc = 0;
    int          obs_miss = 0;
    int          viol     = 0;
    logic        rd_phase = 1'b0;
    logic [15:0] obs_q[$];
    int          lat_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wr_valid) begin
            obs_q.push_back({wr_addr, wr_data});
            lat_q.push_back(cyc - rise_cyc);
        end
        if (miss) obs_miss++;
        if (!rd_phase && !m_low && sda_bus !== 1'b1) viol++;
    end

    // Reference model: transaction-level view of the bus
    logic [15:0] exp_q[$];
    int          exp_miss    = 0;
    logic [7:0]  exp_rd_addr = 8'h00;
    logic [7:0]  exp_wr_data = 8'h00;

    function automatic void model_txn(input logic [7:0] bytes[$]);
        if (bytes[0] != DEV) begin
            exp_miss++;
            return;
        end
        if (bytes.size() >= 2) exp_rd_addr = bytes[1];
        if (bytes.size() >= 3) begin
            exp_q.push_back({bytes[1], bytes[2]});
            exp_wr_data = bytes[2];
        end
    endfunction

    // Bus driver
    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_bit(input logic b);
        m_low = ~b;
        wait_clks(Q);
        scl = 1'b1;
        rise_cyc = cyc;
        wait_clks(2 * Q);
        scl = 1'b0;
        wait_clks(Q);
    endtask

    task automatic send_bits(input logic [7:0] b, input int nbits);
        for (int i = 7; i > 7 - nbits; i--) send_bit(b[i]);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(b, 8);
        send_bit(1'b1);
    endtask

    task automatic send_start;
        m_low = 1'b0;
        wait_clks(Q);
        scl = 1'b1;
        wait_clks(Q);
        m_low = 1'b1;
        wait_clks(Q);
        scl = 1'b0;
        wait_clks(Q);
    endtask

    task automatic send_stop;
        m_low = 1'b1;
        wait_clks(Q);
        scl = 1'b1;
        wait_clks(Q);
        m_low = 1'b0;
        wait_clks(2 * Q);
    endtask

    task automatic run_txn(input logic [7:0] bytes[$], input int partial);
        logic [7:0] pb;
        pb = 8'($urandom);
        send_start;
        check("busy_after_start", busy, 1);
        foreach (bytes[i]) send_byte(bytes[i]);
        if (partial > 0) send_bits(pb, partial);
        send_stop;
        model_txn(bytes);
    endtask

    task automatic scoreboard(input string tag);
        check({tag, "_strobe_count"}, obs_q.size(), exp_q.size());
        while (obs_q.size() > 0 && exp_q.size() > 0)
            check({tag, "_wr_pair"}, obs_q.pop_front(), exp_q.pop_front());
        obs_q.delete();
        exp_q.delete();
        while (lat_q.size() > 0)
            check({tag, "_strobe_latency"}, lat_q.pop_front(), SYNC + 1);
        check({tag, "_miss_count"}, obs_miss, exp_miss);
        check({tag, "_rd_addr"}, rd_addr, exp_rd_addr);
        check({tag, "_wr_data_hold"}, wr_data, exp_wr_data);
        check({tag, "_busy_after_stop"}, busy, 0);
        check({tag, "_sda_not_driven"}, viol, 0);
    endtask

    logic [15:0] cam_tab [12] = '{16'h1280, 16'h1101, 16'h3A04, 16'h1200,
                                  16'h1713, 16'h1801, 16'h32B6, 16'h1902,
                                  16'h1A7A, 16'h030A, 16'h0C00, 16'h3E00};

    initial begin
        logic [7:0] txq[$];
        logic [7:0] dev;
        logic [7:0] got;
        int         n;
        int         partial;

        // Reset values
        wait_clks(3);
        check("rst_wr_valid", wr_valid, 0);
        check("rst_addr_miss", miss, 0);
        check("rst_busy", busy, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_sda_released", sda_bus, 1);
        rst_n = 1'b1;
        wait_clks(4);

        // Basic 3-phase write
        txq = {DEV, 8'h12, 8'h80};
        run_txn(txq, 0);
        scoreboard("write_basic");

        // Camera init sequence, back to back
        for (int i = 0; i < 12; i++) begin
            txq = {DEV, cam_tab[i][15:8], cam_tab[i][7:0]};
            run_txn(txq, 0);
        end
        scoreboard("camera_init");

        // Foreign device address
        txq = {8'h60, 8'h12, 8'h34};
        run_txn(txq, 0);
        scoreboard("addr_miss");

        // STOP after 4 bits of the data byte, then a full write
        txq = {DEV, 8'h12};
        run_txn(txq, 4);
        scoreboard("partial_data");
        txq = {DEV, 8'h55, 8'hAA};
        run_txn(txq, 0);
        scoreboard("after_partial");

        // Repeated START abandons the first segment
        send_start;
        send_byte(DEV);
        send_byte(8'h05);
        txq = {DEV, 8'h05};
        model_txn(txq);
        txq = {DEV, 8'h21, 8'h9C};
        run_txn(txq, 0);
        scoreboard("repeated_start");

        // Randomized transactions
        for (int t = 0; t < 25; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                dev = 8'($urandom);
                while (dev == DEV || dev == (DEV | 8'h01)) dev = 8'($urandom);
            end else begin
                dev = DEV;
            end
            n = $urandom_range(1, 4);
            txq.delete();
            txq.push_back(dev);
            for (int i = 1; i < n; i++) txq.push_back(8'($urandom));
            partial = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0;
            run_txn(txq, partial);
        end
        scoreboard("random");

        // Read address
`ifdef SCCB_READ_EN
        txq = {DEV, 8'h0A};
        run_txn(txq, 0);
        rd_data = 8'h76;
        send_start;
        send_bits(DEV | 8'h01, 8);
        m_low = 1'b0;
        wait_clks(Q);
        scl = 1'b1;
        wait_clks(2 * Q);
        rd_phase = 1'b1;
        scl = 1'b0;
        wait_clks(Q);
        got = 8'h00;
        for (int i = 0; i < 8; i++) begin
            wait_clks(Q);
            scl = 1'b1;
            wait_clks(Q);
            got = {got[6:0], sda_bus};
            wait_clks(Q);
            scl = 1'b0;
            wait_clks(Q);
        end
        wait_clks(Q);
        scl = 1'b1;
        wait_clks(Q);
        check("read_na_released", sda_bus, 1);
        rd_phase = 1'b0;
        wait_clks(Q);
        scl = 1'b0;
        wait_clks(Q);
        send_stop;
        check("read_byte", got, 8'h76);
        scoreboard("read");
`else
        txq = {DEV | 8'h01, 8'h12};
        run_txn(txq, 0);
        scoreboard("read_as_miss");
`endif

        // Reset in the middle of the register address byte
        send_start;
        send_byte(DEV);
        send_bits(8'hA5, 4);
        rst_n = 1'b0;
        #1;
        check("midrst_wr_valid", wr_valid, 0);
        check("midrst_addr_miss", miss, 0);
        check("midrst_busy", busy, 0);
        check("midrst_wr_addr", wr_addr, 0);
        check("midrst_wr_data", wr_data, 0);
        check("midrst_rd_addr", rd_addr, 0);
        exp_rd_addr = 8'h00;
        exp_wr_data = 8'h00;
        m_low = 1'b0;
        scl   = 1'b1;
        wait_clks(3);
        rst_n = 1'b1;
        wait_clks(4);
        txq = {DEV, 8'h3C, 8'hC3};
        run_txn(txq, 0);
        scoreboard("after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
